// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the registered ALU, the result buffer and the
// downstream consumer. The buffer uses the slave modport; the environment
// (ALU and writeback/display logic) uses the master modport.
interface alu_result_buffer_if #(
    parameter int NUMBITS = 16
) ();
    // ALU -> buffer
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] result;
    logic               carryout;
    logic               overflow;
    logic               zero;
    logic [2:0]         opcode;
    // buffer -> consumer
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] out_result;
    logic               out_carry;
    logic               out_overflow;
    logic               out_zero;
    logic [2:0]         out_opcode;

    modport master (
        output in_valid, result, carryout, overflow, zero, opcode, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_overflow,
               out_zero, out_opcode
    );

    modport slave (
        input  in_valid, result, carryout, overflow, zero, opcode, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_overflow,
               out_zero, out_opcode
    );
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: DEPTH-entry first-word-fall-through FIFO behind the ALU.
// Captures {opcode, zero, overflow, carryout, result} on each accepted
// in_valid, presents the head on out_* with a valid/ready handshake, and
// counts results rejected while full (saturating).
// Optional feature: define STICKY_FLAGS_EN to add clear_sticky and the
// sticky_carry / sticky_overflow outputs.
module alu_result_buffer #(
    parameter int NUMBITS = 16,
    parameter int DEPTH   = 4,
    parameter int DROPW   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    alu_result_buffer_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [DROPW-1:0]           drop_count
`ifdef STICKY_FLAGS_EN
    ,
    input  logic                       clear_sticky,
    output logic                       sticky_carry,
    output logic                       sticky_overflow
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [2:0]         opcode;
        logic               zero;
        logic               overflow;
        logic               carry;
        logic [NUMBITS-1:0] result;
    } entry_t;

    // Storage is deliberately left out of reset; count/pointers define validity.
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [DROPW-1:0] drop_q;
    logic            push;
    logic            pop;
    entry_t          wr_entry;
    entry_t          head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign drop_count = drop_q;

    // No pass-through when full: a pop that cycle does not open a slot.
    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign push = bus.in_valid & ~full;
    assign pop  = ~empty & bus.out_ready;

    assign wr_entry = '{opcode:   bus.opcode,
                        zero:     bus.zero,
                        overflow: bus.overflow,
                        carry:    bus.carryout,
                        result:   bus.result};

    // Head fall-through, zeroed when empty so no stale entry is visible.
    assign head = empty ? '0 : mem[rd_ptr];
    assign bus.out_result   = head.result;
    assign bus.out_carry    = head.carry;
    assign bus.out_overflow = head.overflow;
    assign bus.out_zero     = head.zero;
    assign bus.out_opcode   = head.opcode;

    // Entry write on accepted push.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Pointer, occupancy and drop-counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.in_valid && full && !(&drop_q)) drop_q <= drop_q + 1'b1;
        end
    end

`ifdef STICKY_FLAGS_EN
    // Sticky flags: set on a pushed flag, cleared on request, set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_carry    <= 1'b0;
            sticky_overflow <= 1'b0;
        end else begin
            if (push && bus.carryout) sticky_carry <= 1'b1;
            else if (clear_sticky)    sticky_carry <= 1'b0;
            if (push && bus.overflow) sticky_overflow <= 1'b1;
            else if (clear_sticky)    sticky_overflow <= 1'b0;
        end
    end
`endif
endmodule
